// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: memory request/return, EXE redirect and the
// decoupled instruction stream handed to decode.
interface fetch_queue_if #(
  parameter int ARQ    = 16,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 4
);
  logic                       pc_en;
  logic                       branch_taken;
  logic [ADDR_W-1:0]          jaddr;
  logic                       imem_req;
  logic [ADDR_W-1:0]          imem_addr;
  logic [ARQ-1:0]             imem_data;
  logic [ARQ-1:0]             instr_out;
  logic [ADDR_W-1:0]          instr_pc;
  logic                       instr_valid;
  logic                       id_ready;
  logic [$clog2(DEPTH):0]     count;

  // Fetch unit side
  modport master (
    input  pc_en, branch_taken, jaddr, imem_data, id_ready,
    output imem_req, imem_addr, instr_out, instr_pc, instr_valid, count
  );

  // Environment side (memory, EXE, decode)
  modport slave (
    output pc_en, branch_taken, jaddr, imem_data, id_ready,
    input  imem_req, imem_addr, instr_out, instr_pc, instr_valid, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end with a DEPTH-entry decoupling queue.
// The PC issues one request per cycle while credit remains; the returning
// word is queued together with its PC, decode pops the head, and a taken
// branch throws away everything queued or outstanding.
module fetch_queue #(
  parameter int                 ARQ      = 16,
  parameter int                 ADDR_W   = 13,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              kill;

  logic [ARQ-1:0]    q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic [CNT_W-1:0]  occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              not_empty;

  // The outstanding request reserves a slot so a return always has room.
  assign occupancy = cnt + CNT_W'(inflight);
  assign not_empty = (cnt != '0);
  assign issue = rst & bus.pc_en & ~bus.branch_taken & (occupancy < DEPTH_CNT);
  assign push  = rst & ~bus.branch_taken & inflight & ~kill;
  assign pop   = rst & ~bus.branch_taken & not_empty & bus.id_ready;

  // PC, in-flight tracking, pointers and occupancy; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
    end else if (bus.branch_taken) begin
      pc       <= bus.jaddr;
      kill     <= inflight;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      kill     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage: returned word and its PC land at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_data;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = not_empty;
  assign bus.instr_out   = not_empty ? q_instr[rd_ptr] : '0;
  assign bus.instr_pc    = not_empty ? q_pc[rd_ptr] : '0;
  assign bus.count       = cnt;

endmodule
